// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder.
//   WHB_*   : access size/sign encoding (funct3) driven by the pipeline.
//   state_t : responder FSM states.
//   whb_legal(): true for the five encodings the responder implements.
package dmem_resp_pkg;

    localparam logic [2:0] WHB_B  = 3'b000;
    localparam logic [2:0] WHB_H  = 3'b001;
    localparam logic [2:0] WHB_W  = 3'b010;
    localparam logic [2:0] WHB_BU = 3'b100;
    localparam logic [2:0] WHB_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic whb_legal(input logic [2:0] whb);
        return (whb == WHB_B) || (whb == WHB_H) || (whb == WHB_W) ||
               (whb == WHB_BU) || (whb == WHB_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores (purely combinational).
//   byte_off   in  2  : offset[1:0] of the access
//   whb        in  3  : size/sign encoding
//   old_word   in  32 : current contents of the addressed word
//   wdata      in  32 : right-aligned store data
//   load_data  out 32 : extracted and extended load value
//   store_word out 32 : old_word with the selected lanes replaced
//   misalign   out 1  : halfword on odd byte or word not on a word boundary
//   illegal    out 1  : whb is outside the five supported encodings
module dmem_lane_align
    import dmem_resp_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  whb,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign,
    output logic        illegal
);

    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign byte_pos = {byte_off, 3'b000};
    assign half_pos = {byte_off[1], 4'b0000};
    assign sel_byte = old_word[byte_pos +: 8];
    assign sel_half = old_word[half_pos +: 16];

    always_comb begin
        load_data  = '0;
        store_word = old_word;
        case (whb)
            WHB_B: begin
                load_data = {{24{sel_byte[7]}}, sel_byte};
                store_word[byte_pos +: 8] = wdata[7:0];
            end
            WHB_BU: begin
                load_data = {24'h0, sel_byte};
                store_word[byte_pos +: 8] = wdata[7:0];
            end
            WHB_H: begin
                load_data = {{16{sel_half[15]}}, sel_half};
                store_word[half_pos +: 16] = wdata[15:0];
            end
            WHB_HU: begin
                load_data = {16'h0, sel_half};
                store_word[half_pos +: 16] = wdata[15:0];
            end
            WHB_W: begin
                load_data  = old_word;
                store_word = wdata;
            end
            default: begin
                load_data  = '0;
                store_word = old_word;
            end
        endcase
    end

    assign misalign = (((whb == WHB_H) || (whb == WHB_HU)) && byte_off[0]) ||
                      ((whb == WHB_W) && (byte_off != 2'b00));
    assign illegal  = !whb_legal(whb);

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the stage-4 load/store port.
// One request at a time over valid/ready, WAIT_CYCLES wait states,
// one registered response pulse per accepted request.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake
//   req_we/addr/wdata/whb: request fields (captured on acceptance only)
//   rsp_valid            : one-cycle response pulse
//   rsp_rdata            : extended load data, 0 for stores and errors
//   rsp_err              : request rejected (range, alignment, encoding)
//   busy                 : FSM not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request
// WAIT  | counting wait states; access happens when cnt reaches 0
// RESP  | rsp_valid high for this single cycle
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_whb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cap_we;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [2:0]         cap_whb;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [31:0]        offset;
    logic [31:0]        word_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic               idx_oob;
    logic               store_unsigned;
    logic               acc_err;
    logic               access_now;
    logic               do_write;
    logic [31:0]        old_word;
    logic [31:0]        load_data;
    logic [31:0]        store_word;
    logic               misalign;
    logic               illegal;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign offset         = cap_addr - BASE_ADDR;
    assign word_idx       = {2'b00, offset[31:2]};
    assign mem_idx        = word_idx[IDX_W-1:0];
    assign idx_oob        = (word_idx >= 32'(DEPTH_WORDS));
    assign store_unsigned = cap_we && ((cap_whb == WHB_BU) || (cap_whb == WHB_HU));
    assign acc_err        = idx_oob || misalign || illegal || store_unsigned;

    // mem_idx aliases a valid word when out of range; acc_err masks the result.
    assign old_word   = mem[mem_idx];
    assign access_now = (state == WAIT) && (cnt == '0);
    // Reset on the access edge must suppress the write.
    assign do_write   = access_now && cap_we && !acc_err && !rst;

    assign req_ready  = (state == IDLE) && !rst;

    dmem_lane_align u_lane_align (
        .byte_off   (offset[1:0]),
        .whb        (cap_whb),
        .old_word   (old_word),
        .wdata      (cap_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (misalign),
        .illegal    (illegal)
    );

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[mem_idx] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_whb   <= WHB_W;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_whb   <= req_whb;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        state     <= WAIT;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || cap_we) ? 32'h0 : load_data;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a default instance (WAIT_CYCLES=2,
// BASE_ADDR=0), a BASE_ADDR=0x8000 instance fed the same requests, and a
// WAIT_CYCLES=0 instance driven with back-to-back requests.
module tb_dmem_responder;

    localparam int WAIT_MAIN = 2;

    logic        clk;
    logic        rst;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_whb;

    logic        m_ready, m_rsp_valid, m_err, m_busy;
    logic [31:0] m_rdata;
    logic        b_ready, b_rsp_valid, b_err, b_busy;
    logic [31:0] b_rdata;

    logic        w0_valid, w0_we;
    logic [31:0] w0_addr, w0_wdata;
    logic [2:0]  w0_whb;
    logic        w0_ready, w0_rsp_valid, w0_err, w0_busy;
    logic [31:0] w0_rdata;

    int          n_checks;
    int          n_errors;
    logic [31:0] b_rd_s;
    logic        b_er_s;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_MAIN), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(m_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_whb(req_whb),
        .rsp_valid(m_rsp_valid), .rsp_rdata(m_rdata), .rsp_err(m_err), .busy(m_busy)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_MAIN), .BASE_ADDR(32'h0000_8000)) u_dut_base (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_whb(req_whb),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(w0_valid), .req_ready(w0_ready), .req_we(w0_we),
        .req_addr(w0_addr), .req_wdata(w0_wdata), .req_whb(w0_whb),
        .rsp_valid(w0_rsp_valid), .rsp_rdata(w0_rdata), .rsp_err(w0_err), .busy(w0_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on the shared request bus; checks latency,
    // response data/error of the default instance and the one-cycle pulse.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] whb,
                        input logic [31:0] exp_rd, input logic exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) check_val({tag, "_ready"}, {31'b0, m_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_whb   = whb;
        @(posedge clk);
        @(negedge clk);
        // Garbage on the bus after acceptance must be ignored.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        req_whb   = 3'b111;
        n = 1;
        while (!m_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_lat"}, 32'(n - 1), 32'(WAIT_MAIN + 1));
        check_val({tag, "_rd"}, m_rdata, exp_rd);
        check_val({tag, "_err"}, {31'b0, m_err}, {31'b0, exp_err});
        b_rd_s = b_rdata;
        b_er_s = b_err;
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'b0, m_rsp_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        int n;
        logic [8:0] ready_vec;
        logic [8:0] busy_vec;
        logic [8:0] rv_vec;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_whb   = 3'b010;
        w0_valid  = 1'b0;
        w0_we     = 1'b0;
        w0_addr   = '0;
        w0_wdata  = '0;
        w0_whb    = 3'b010;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'b0, m_ready}, 32'd0);
        check_val("rst_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
        check_val("rst_rdata", m_rdata, 32'd0);
        check_val("rst_err", {31'b0, m_err}, 32'd0);
        check_val("rst_busy", {31'b0, m_busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", {31'b0, m_ready}, 32'd1);

        xact("sw10",   1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
        xact("lw10",   1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0);
        xact("sb11",   1'b1, 32'h11, 32'hFFFF_FF5A, 3'b000, 32'h0, 1'b0);
        xact("lw10b",  1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_5AEF, 1'b0);
        xact("lb13",   1'b0, 32'h13, 32'h0,         3'b000, 32'hFFFF_FFDE, 1'b0);
        xact("lbu13",  1'b0, 32'h13, 32'h0,         3'b100, 32'h0000_00DE, 1'b0);
        xact("lhu12",  1'b0, 32'h12, 32'h0,         3'b101, 32'h0000_DEAD, 1'b0);
        xact("lh12",   1'b0, 32'h12, 32'h0,         3'b001, 32'hFFFF_DEAD, 1'b0);
        xact("lb10",   1'b0, 32'h10, 32'h0,         3'b000, 32'hFFFF_FFEF, 1'b0);
        xact("lh10",   1'b0, 32'h10, 32'h0,         3'b001, 32'h0000_5AEF, 1'b0);

        xact("lh11",   1'b0, 32'h11, 32'h0,         3'b001, 32'h0, 1'b1);
        xact("sw12",   1'b1, 32'h12, 32'h0,         3'b010, 32'h0, 1'b1);
        xact("whb011", 1'b0, 32'h10, 32'h0,         3'b011, 32'h0, 1'b1);
        xact("sbu10",  1'b1, 32'h10, 32'h0,         3'b100, 32'h0, 1'b1);
        xact("whb110", 1'b0, 32'h10, 32'h0,         3'b110, 32'h0, 1'b1);
        xact("lw10c",  1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_5AEF, 1'b0);

        xact("sh12",   1'b1, 32'h12, 32'hABCD_1234, 3'b001, 32'h0, 1'b0);
        xact("lw10d",  1'b0, 32'h10, 32'h0,         3'b010, 32'h1234_5AEF, 1'b0);
        xact("sb13",   1'b1, 32'h13, 32'h0000_0080, 3'b000, 32'h0, 1'b0);
        xact("lw10e",  1'b0, 32'h10, 32'h0,         3'b010, 32'h8034_5AEF, 1'b0);
        xact("lb13b",  1'b0, 32'h13, 32'h0,         3'b000, 32'hFFFF_FF80, 1'b0);
        xact("lbu12",  1'b0, 32'h12, 32'h0,         3'b100, 32'h0000_0034, 1'b0);

        xact("lw1000", 1'b0, 32'h1000, 32'h0,       3'b010, 32'h0, 1'b1);
        xact("swffc",  1'b1, 32'hFFC, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0);
        xact("lwffc",  1'b0, 32'hFFC, 32'h0,        3'b010, 32'hCAFE_F00D, 1'b0);

        xact("lw7ffc", 1'b0, 32'h7FFC, 32'h0,       3'b010, 32'h0, 1'b1);
        check_val("base_lw7ffc_err", {31'b0, b_er_s}, 32'd1);
        check_val("base_lw7ffc_rd", b_rd_s, 32'd0);
        xact("sw8004", 1'b1, 32'h8004, 32'h1122_3344, 3'b010, 32'h0, 1'b1);
        check_val("base_sw8004_err", {31'b0, b_er_s}, 32'd0);
        xact("lw8004", 1'b0, 32'h8004, 32'h0,       3'b010, 32'h0, 1'b1);
        check_val("base_lw8004_err", {31'b0, b_er_s}, 32'd0);
        check_val("base_lw8004_rd", b_rd_s, 32'h1122_3344);

        // Reset asserted on the access edge of a store aborts it.
        xact("sw20",   1'b1, 32'h20, 32'h0,         3'b010, 32'h0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!m_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1;
        req_whb   = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("abort_busy_pre", {31'b0, m_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_ready_in_rst", {31'b0, m_ready}, 32'd0);
        check_val("abort_busy", {31'b0, m_busy}, 32'd0);
        check_val("abort_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_rsp_valid) seen++;
        end
        check_val("abort_no_rsp", 32'(seen), 32'd0);
        xact("lw20",   1'b0, 32'h20, 32'h0,         3'b010, 32'h0, 1'b0);

        // Back-to-back requests with zero wait states.
        @(negedge clk);
        w0_valid = 1'b1;
        ready_vec = '0;
        busy_vec  = '0;
        rv_vec    = '0;
        for (int i = 0; i < 9; i++) begin
            ready_vec[i] = w0_ready;
            busy_vec[i]  = w0_busy;
            rv_vec[i]    = w0_rsp_valid;
            @(negedge clk);
        end
        w0_valid = 1'b0;
        check_val("w0_ready_pattern", {23'b0, ready_vec}, 32'h049);
        check_val("w0_busy_pattern", {23'b0, busy_vec}, 32'h1B6);
        check_val("w0_rsp_pattern", {23'b0, rv_vec}, 32'h124);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU's stage-4 load/store interface. It accepts one request at a time through a valid/ready handshake and models a configurable number of wait states. Each request is a read or write of byte, halfword or word size, selected by the same `whb` (funct3) encoding the pipeline drives. The block stores data in an internal word array and returns one registered response per accepted request, with an error flag.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two.
- `WAIT_CYCLES`, 2: extra cycles between acceptance and access; 0 is legal.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request.
- `req_we`  in  1: 1 = store, 0 = load (MemRW).
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `req_whb`  in  3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rsp_valid`  out  1: response pulse, one cycle.
- `rsp_rdata`  out  32: load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err`  out  1: request was rejected.
- `busy`  out  1: asserted when the FSM is not in IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP. `req_ready` = (state==IDLE) && !rst.
- IDLE: when `req_valid && req_ready` at an edge, capture we/addr/wdata/whb, load `cnt` with WAIT_CYCLES and go to WAIT.
- WAIT: if `cnt`!=0, decrement it. If `cnt`==0, perform the access at this edge, register the response, and go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, with no backpressure; the next edge returns to IDLE.
- Offset = addr - BASE_ADDR, truncated to 32 bits. Word index = offset[31:2].
- An error is any of the following; on error there is no array write, `rsp_rdata`=0 and `rsp_err`=1:
  - index >= DEPTH_WORDS;
  - H/HU with offset[0]=1;
  - W with offset[1:0]!=0;
  - whb in {011,110,111};
  - a store with whb in {100,101}.
- Load B/BU: byte select = offset[1:0]; B is sign-extended, BU is zero-extended.
- Load H/HU: select the half given by offset[1]; H is sign-extended, HU is zero-extended.
- Store: read-modify-write of the addressed word. Only the selected byte lanes change.
- Array contents are not reset and are not initialised by the block.

## Timing
- Reset values: state IDLE, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `busy` 0, `cnt` 0. `req_ready` is 0 while `rst`=1.
- Acceptance at edge E0 → access at edge E0+WAIT_CYCLES+1. `rsp_valid` is high in the cycle after that edge. `req_ready` rises one cycle later.
- Throughput: one request every WAIT_CYCLES+3 cycles.
- Store data is visible to a load accepted after the store's RESP cycle.
- `req_*` inputs are ignored outside the accepting edge; requests held during WAIT/RESP are not queued.
- Reset during WAIT aborts the request: no write occurs and no response is issued. Reset on the access edge takes priority, so the write is suppressed.
- Reset during RESP clears `rsp_valid` on that edge.

## Structure
- Package `dmem_resp_pkg` holds:
  - the `whb` encoding localparams (`WHB_B`, `WHB_H`, `WHB_W`, `WHB_BU`, `WHB_HU`);
  - typedef `state_t` {IDLE, WAIT, RESP}.
- Sub-module `dmem_lane_align` is combinational. It takes offset[1:0], whb, the old word and wdata. It produces the load-extracted value, the merged store word and the misalign/illegal flags.
- The top module holds the FSM, counter, capture registers and array.

## Test plan
- WAIT_CYCLES=2, SW 0xDEADBEEF @0x10 accepted at E0 → `rsp_valid` after E3, `rsp_err`=0, `rsp_rdata`=0; then LW @0x10 → 0xDEADBEEF.
- With 0x10 = 0xDEADBEEF: SB 0x5A @0x11, then LW @0x10 → 0xDEAD5AEF. LB @0x13 → 0xFFFFFFDE. LBU @0x13 → 0x000000DE. LHU @0x12 → 0x0000DEAD.
- LH @0x11, SW @0x12 and whb=011 → `rsp_err`=1, `rsp_rdata`=0; a later LW @0x10 shows the word unchanged.
- DEPTH_WORDS=1024, LW @0x1000 → `rsp_err`=1. BASE_ADDR=0x8000: LW @0x7FFC → `rsp_err`=1 (wraps to a large offset).
- WAIT_CYCLES=0, back-to-back `req_valid`=1 → accepts exactly every 3 cycles; `busy` is high 2 of every 3 cycles.
- Assert `rst` in WAIT of SW 0x1 @0x20 (0x20 previously held 0x0) → no `rsp_valid`; after release, LW @0x20 returns 0x0.
